// File: rtl/sap1_pkg.sv
// SAP-1 shared constants: opcodes, T-state one-hot codes, control-word bit map.
package sap1_pkg;

   localparam int RING_LEN = 6;
   localparam int OPCODE_W = 4;

   typedef logic [RING_LEN-1:0] tstate_t;
   typedef logic [OPCODE_W-1:0] opcode_t;

   // Opcodes decoded from IR[7:4]
   localparam opcode_t OP_LDA = 4'h0;
   localparam opcode_t OP_ADD = 4'h1;
   localparam opcode_t OP_SUB = 4'h2;
   localparam opcode_t OP_OUT = 4'hE;
   localparam opcode_t OP_HLT = 4'hF;

   // One-hot T-states
   localparam tstate_t T1 = 6'b000001;
   localparam tstate_t T2 = 6'b000010;
   localparam tstate_t T3 = 6'b000100;
   localparam tstate_t T4 = 6'b001000;
   localparam tstate_t T5 = 6'b010000;
   localparam tstate_t T6 = 6'b100000;

   // Control-word bit positions
   localparam int CW_W       = 13;
   localparam int CW_PC_INC  = 12;
   localparam int CW_PC_OUT  = 11;
   localparam int CW_MAR_IN  = 10;
   localparam int CW_RAM_OUT = 9;
   localparam int CW_IR_IN   = 8;
   localparam int CW_IR_OUT  = 7;
   localparam int CW_ACC_IN  = 6;
   localparam int CW_ACC_OUT = 5;
   localparam int CW_B_IN    = 4;
   localparam int CW_SUB     = 3;
   localparam int CW_ULA_OUT = 2;
   localparam int CW_OUT_IN  = 1;
   localparam int CW_HLT     = 0;

   typedef logic [CW_W-1:0] cword_t;

endpackage

// File: rtl/anel_contador_tstates.sv
// One-hot T-state ring counter. Rotates every clock unless held; any
// corrupted (non-one-hot) value is pulled back to T1 on the next edge.
module anel_contador_tstates #(
   parameter int RING_LEN = 6
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                hold,
   output logic [RING_LEN-1:0] t_state
);

   localparam logic [RING_LEN-1:0] FIRST = {{(RING_LEN-1){1'b0}}, 1'b1};

   logic [RING_LEN-1:0] ring;

   // Ring register: clear wins, then one-hot repair, then hold, else rotate left
   always_ff @(posedge clock) begin
      if (clear)
         ring <= FIRST;
      else if (!$onehot(ring))
         ring <= FIRST;
      else if (!hold)
         ring <= {ring[RING_LEN-2:0], ring[RING_LEN-1]};
   end

   assign t_state = ring;

endmodule

// File: rtl/controlador_sequenciador.sv
// SAP-1 controller-sequencer: T-state ring, sticky halt flag and the
// combinational decode that turns (T-state, opcode) into bus strobes.
module controlador_sequenciador #(
   parameter int RING_LEN = sap1_pkg::RING_LEN,
   parameter int OPCODE_W = sap1_pkg::OPCODE_W
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [OPCODE_W-1:0] opcode,
   output logic [RING_LEN-1:0] t_state,
   output logic                PC_INC,
   output logic                PC_OUT,
   output logic                MAR_IN,
   output logic                RAM_OUT,
   output logic                IR_IN,
   output logic                IR_OUT,
   output logic                ACC_IN,
   output logic                ACC_OUT,
   output logic                B_IN,
   output logic                SUB,
   output logic                ULA_OUT,
   output logic                OUT_IN,
   output logic                HLT
);

   import sap1_pkg::*;

   logic   halt_q;
   logic   halt_det;
   logic   hold;
   cword_t cw;

   // HLT seen in T4 freezes the ring immediately (no T5) and latches the flag
   assign halt_det = (t_state == T4) && (opcode == OP_HLT);
   assign hold     = halt_q | halt_det;

   anel_contador_tstates #(.RING_LEN(RING_LEN)) u_anel (
      .clock   (clock),
      .clear   (clear),
      .hold    (hold),
      .t_state (t_state)
   );

   // Sticky halt flag; only clear releases it
   always_ff @(posedge clock) begin
      if (clear)
         halt_q <= 1'b0;
      else if (halt_det)
         halt_q <= 1'b1;
   end

   // Control-word decode: fetch is opcode-independent, execute keys on opcode
   always_comb begin
      cw = '0;
      if (hold) begin
         cw[CW_HLT] = 1'b1;
      end else begin
         case (t_state)
            T1: begin
               cw[CW_PC_OUT] = 1'b1;
               cw[CW_MAR_IN] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
               cw[CW_RAM_OUT] = 1'b1;
               cw[CW_IR_IN]   = 1'b1;
            end
            T4: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     cw[CW_IR_OUT] = 1'b1;
                     cw[CW_MAR_IN] = 1'b1;
                  end
                  OP_OUT: begin
                     cw[CW_ACC_OUT] = 1'b1;
                     cw[CW_OUT_IN]  = 1'b1;
                  end
                  default: ;
               endcase
            end
            T5: begin
               case (opcode)
                  OP_LDA: begin
                     cw[CW_RAM_OUT] = 1'b1;
                     cw[CW_ACC_IN]  = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     cw[CW_RAM_OUT] = 1'b1;
                     cw[CW_B_IN]    = 1'b1;
                  end
                  default: ;
               endcase
            end
            T6: begin
               case (opcode)
                  OP_ADD: begin
                     cw[CW_ULA_OUT] = 1'b1;
                     cw[CW_ACC_IN]  = 1'b1;
                  end
                  OP_SUB: begin
                     cw[CW_ULA_OUT] = 1'b1;
                     cw[CW_ACC_IN]  = 1'b1;
                     cw[CW_SUB]     = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign PC_INC  = cw[CW_PC_INC];
   assign PC_OUT  = cw[CW_PC_OUT];
   assign MAR_IN  = cw[CW_MAR_IN];
   assign RAM_OUT = cw[CW_RAM_OUT];
   assign IR_IN   = cw[CW_IR_IN];
   assign IR_OUT  = cw[CW_IR_OUT];
   assign ACC_IN  = cw[CW_ACC_IN];
   assign ACC_OUT = cw[CW_ACC_OUT];
   assign B_IN    = cw[CW_B_IN];
   assign SUB     = cw[CW_SUB];
   assign ULA_OUT = cw[CW_ULA_OUT];
   assign OUT_IN  = cw[CW_OUT_IN];
   assign HLT     = cw[CW_HLT];

endmodule

// File: tb/tb_controlador_sequenciador.sv
// Scoreboard bench for the SAP-1 controller-sequencer.
module tb_controlador_sequenciador;

   // Bench-side strobe positions: {PC_INC,PC_OUT,MAR_IN,RAM_OUT,IR_IN,IR_OUT,
   //  ACC_IN,ACC_OUT,B_IN,SUB,ULA_OUT,OUT_IN,HLT}
   localparam int S_PCINC = 12, S_PCOUT = 11, S_MARIN = 10, S_RAMOUT = 9,
                  S_IRIN = 8, S_IROUT = 7, S_ACCIN = 6, S_ACCOUT = 5,
                  S_BIN = 4, S_SUB = 3, S_ULAOUT = 2, S_OUTIN = 1, S_HLT = 0;

   typedef struct packed {
      logic [5:0]  t;
      logic [12:0] s;
   } exp_t;

   logic       clock = 1'b0;
   logic       clear = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic [5:0] t_state;
   logic PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT, ACC_IN, ACC_OUT;
   logic B_IN, SUB, ULA_OUT, OUT_IN, HLT;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   // Reference model state: instruction step 0..5 and halted flag
   int   ph = 0;
   bit   hl = 1'b0;
   bit   known = 1'b0;

   controlador_sequenciador dut (
      .clock(clock), .clear(clear), .opcode(opcode), .t_state(t_state),
      .PC_INC(PC_INC), .PC_OUT(PC_OUT), .MAR_IN(MAR_IN), .RAM_OUT(RAM_OUT),
      .IR_IN(IR_IN), .IR_OUT(IR_OUT), .ACC_IN(ACC_IN), .ACC_OUT(ACC_OUT),
      .B_IN(B_IN), .SUB(SUB), .ULA_OUT(ULA_OUT), .OUT_IN(OUT_IN), .HLT(HLT)
   );

   always #5 clock = ~clock;

   // Expected strobes from the instruction table
   function automatic logic [12:0] model_word(int p, bit h, logic [3:0] op);
      logic [12:0] w;
      w = '0;
      if (h || (p == 3 && op == 4'hF)) begin
         w[S_HLT] = 1'b1;
         return w;
      end
      case (p)
         0: begin w[S_PCOUT] = 1'b1; w[S_MARIN] = 1'b1; end
         1: w[S_PCINC] = 1'b1;
         2: begin w[S_RAMOUT] = 1'b1; w[S_IRIN] = 1'b1; end
         3: if (op <= 4'h2) begin w[S_IROUT] = 1'b1; w[S_MARIN] = 1'b1; end
            else if (op == 4'hE) begin w[S_ACCOUT] = 1'b1; w[S_OUTIN] = 1'b1; end
         4: if (op == 4'h0) begin w[S_RAMOUT] = 1'b1; w[S_ACCIN] = 1'b1; end
            else if (op == 4'h1 || op == 4'h2) begin w[S_RAMOUT] = 1'b1; w[S_BIN] = 1'b1; end
         5: if (op == 4'h1 || op == 4'h2) begin
               w[S_ULAOUT] = 1'b1; w[S_ACCIN] = 1'b1; w[S_SUB] = (op == 4'h2);
            end
         default: ;
      endcase
      return w;
   endfunction

   // One clock: advance model with the inputs seen at this edge, then drive new
   // inputs. Fetch steps get a random opcode since it must be ignored there.
   task automatic step(input logic clr, input logic [3:0] op);
      exp_t e;
      @(posedge clock);
      if (clear) begin
         ph = 0; hl = 1'b0; known = 1'b1;
      end else if (!hl) begin
         if (ph == 3 && opcode == 4'hF) hl = 1'b1;
         else ph = (ph + 1) % 6;
      end
      #1;
      clear  = clr;
      opcode = (ph < 3 && !hl) ? 4'($urandom) : op;
      if (known) begin
         e.t = 6'(1 << ph);
         e.s = model_word(ph, hl, opcode);
         sb.push_back(e);
      end
   endtask

   task automatic instr(input logic [3:0] op);
      for (int i = 0; i < 6; i++) step(1'b0, op);
   endtask

   // Monitor: outputs are valid every cycle; compare mid-cycle
   always @(negedge clock) begin
      exp_t e;
      logic [12:0] act;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         act = {PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT, ACC_IN, ACC_OUT,
                B_IN, SUB, ULA_OUT, OUT_IN, HLT};
         checks++;
         if (t_state !== e.t || act !== e.s) begin
            errors++;
            $display("FAIL word t=%0t t_state=%b strobes=%b expected t_state=%b strobes=%b",
                     $time, t_state, act, e.t, e.s);
         end
         checks++;
         if ($countones({PC_OUT, RAM_OUT, IR_OUT, ACC_OUT, ULA_OUT}) > 1) begin
            errors++;
            $display("FAIL bus_contention t=%0t drivers=%b expected at most one",
                     $time, {PC_OUT, RAM_OUT, IR_OUT, ACC_OUT, ULA_OUT});
         end
         checks++;
         if (!$onehot(t_state)) begin
            errors++;
            $display("FAIL onehot t=%0t t_state=%b expected one-hot", $time, t_state);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held 2 clocks, then a free-running instruction visiting T2..T6
      step(1'b1, 4'h0);
      step(1'b1, 4'h0);
      for (int i = 0; i < 6; i++) step(1'b0, 4'h7);
      instr(4'h0);                      // LDA
      instr(4'h1);                      // ADD
      instr(4'h2);                      // SUB
      instr(4'hE);                      // OUT
      instr(4'hF);                      // HLT (freezes in T4)
      for (int i = 0; i < 20; i++) step(1'b0, 4'hF);
      step(1'b1, 4'hF);                 // clear while halted
      // ADD, clear during T4 so the would-be T5 becomes T1
      for (int i = 0; i < 3; i++) step(1'b0, 4'h1);
      step(1'b1, 4'h1);
      for (int k = 0; k < 16; k++) instr(4'(k));
      // Random opcodes with occasional clears
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 29) == 0), 4'($urandom));
      @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
